kmap_sweeper: RTL and testbench

Self-checking sequencer wrapped around the 3-input K-map logic (`f = A(B'+C) + A'BC' + B'C`). It drives all eight `{a,b,c}` minterms into the combinational K-map block and samples its `f` output for each. The samples are assembled into an 8-bit truth table and compared with an expected pattern. It sits directly upstream of the K-map, feeding `a`/`b`/`c`, and directly downstream of it, consuming `f`. It is the team's standard on-chip exerciser for the K-map stage.

---
 rtl/kmap_sweeper_if.sv | 43 ++++
 rtl/kmap_sweeper.sv | 162 ++++++++++++++++
 tb/tb_kmap_sweeper.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kmap_sweeper_if.sv
// ============================================================================
//  Module      : kmap_sweeper_if
//  Description : Signal bundle between the K-map sweeper and its environment.
//                The master side (the sweeper) drives the minterm, status and
//                result signals; the slave side supplies start and the K-map f.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    start        sweep request (slave -> master)
//    f            K-map output (slave -> master)
//    a, b, c      minterm drive, a is the MSB (master -> slave)
//    busy         sweep in progress
//    done         one-cycle completion pulse
//    truth_table  captured truth table, bit i = f for {a,b,c} = i
//    mismatch     truth_table ^ EXPECT of the last completed sweep
//    pass         last completed sweep matched EXPECT
// ============================================================================
`default_nettype none

interface kmap_sweeper_if;
  logic       start;
  logic       f;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic [7:0] mismatch;
  logic       pass;

  modport master (
    input  start, f,
    output a, b, c, busy, done, truth_table, mismatch, pass
  );

  modport slave (
    output start, f,
    input  a, b, c, busy, done, truth_table, mismatch, pass
  );
endinterface

`default_nettype wire

// File: rtl/kmap_sweeper.sv
// ============================================================================
//  Module      : kmap_sweeper
//  Description : On-chip exerciser for the 3-input K-map stage. Walks {a,b,c}
//                through minterms 0..7, waits SETTLE cycles per minterm,
//                samples f into an 8-bit truth table and compares the result
//                with EXPECT.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE   wait cycles per minterm before f is sampled (0..15)
//    EXPECT   expected truth table, bit i = f for {a,b,c} = i
//  Ports
//    clk      rising-edge clock
//    rst_n    synchronous active-low reset
//    bus      kmap_sweeper_if.master: start/f in; a,b,c, busy, done,
//             truth_table, mismatch, pass out
//  Build option
//    KMAP_SWEEP_STICKY_EN  when defined, pass is sticky-low: once any sweep
//                          fails, pass stays 0 until reset.
// ============================================================================
`default_nettype none

module kmap_sweeper #(
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXPECT = 8'hB6
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  kmap_sweeper_if.master bus
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [2:0] LAST_IDX   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q,    state_d;
  logic [2:0] idx_q,      idx_d;
  logic [3:0] cnt_q,      cnt_d;
  logic [2:0] abc_q,      abc_d;
  logic       busy_q,     busy_d;
  logic       done_q,     done_d;
  logic [7:0] table_q,    table_d;
  logic [7:0] mismatch_q, mismatch_d;
  logic       pass_q,     pass_d;
`ifdef KMAP_SWEEP_STICKY_EN
  // Remembers that some sweep since reset has failed.
  logic       failed_q,   failed_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= 4'd0;
      abc_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= 8'd0;
      mismatch_q <= 8'd0;
      pass_q     <= 1'b0;
`ifdef KMAP_SWEEP_STICKY_EN
      failed_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      abc_q      <= abc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      table_q    <= table_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
`ifdef KMAP_SWEEP_STICKY_EN
      failed_q   <= failed_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    abc_d      = abc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    table_d    = table_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
`ifdef KMAP_SWEEP_STICKY_EN
    failed_d   = failed_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Only the table clears here; mismatch/pass keep the previous
          // result until this sweep finishes.
          table_d = 8'd0;
          idx_d   = 3'd0;
          abc_d   = 3'd0;
          cnt_d   = SETTLE_CNT;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          table_d[idx_q] = bus.f;
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 3'd1;
            abc_d = idx_q + 3'd1;
            cnt_d = SETTLE_CNT;
          end else begin
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            abc_d      = 3'd0;
            // Fold in the bit being captured on this same edge.
            mismatch_d = {bus.f, table_q[6:0]} ^ EXPECT;
`ifdef KMAP_SWEEP_STICKY_EN
            failed_d   = failed_q | (mismatch_d != 8'd0);
            pass_d     = (mismatch_d == 8'd0) && !failed_q;
`else
            pass_d     = (mismatch_d == 8'd0);
`endif
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.a           = abc_q[2];
  assign bus.b           = abc_q[1];
  assign bus.c           = abc_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = table_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.pass        = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_kmap_sweeper.sv
// ============================================================================
//  Module      : tb_kmap_sweeper
//  Description : Self-checking bench for kmap_sweeper (SETTLE=1, EXPECT=B6).
//                The f input is fed from one of three sources: the real K-map
//                equation, a constant 0, or an arbitrary 8-bit pattern looked
//                up by minterm. A reference model derives each sweep's table,
//                mismatch and pass directly from the chosen source.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_kmap_sweeper;

  localparam logic [7:0] EXP_TT = 8'hB6;

  localparam int MODE_KMAP = 0;
  localparam int MODE_ZERO = 1;
  localparam int MODE_PAT  = 2;

  logic clk;
  logic rst_n;

  kmap_sweeper_if bus ();

  kmap_sweeper #(
    .SETTLE (1),
    .EXPECT (EXP_TT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         f_mode       = MODE_KMAP;
  logic [7:0] f_pat        = 8'h00;

  // Model state: result of the last completed sweep
  logic [7:0] m_mis    = 8'h00;
  logic       m_pass   = 1'b0;
  logic       m_failed = 1'b0;

  // K-map equation f = A(B'+C) + A'BC' + B'C
  function automatic logic kmap_eq(input logic A, input logic B, input logic C);
    return (A & (~B | C)) | (~A & B & ~C) | (~B & C);
  endfunction

  always_comb begin
    case (f_mode)
      MODE_KMAP: bus.f = kmap_eq(bus.a, bus.b, bus.c);
      MODE_ZERO: bus.f = 1'b0;
      default:   bus.f = f_pat[{bus.a, bus.b, bus.c}];
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected truth table for the current f source, one minterm at a time.
  function automatic logic [7:0] model_table(input int mode, input logic [7:0] pat);
    logic [7:0] t;
    logic [2:0] m;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m = 3'(i);
      case (mode)
        MODE_KMAP: t[i] = kmap_eq(m[2], m[1], m[0]);
        MODE_ZERO: t[i] = 1'b0;
        default:   t[i] = pat[i];
      endcase
    end
    return t;
  endfunction

  task automatic model_complete(input logic [7:0] tt);
    m_mis = tt ^ EXP_TT;
`ifdef KMAP_SWEEP_STICKY_EN
    if (m_mis != 8'h00) m_failed = 1'b1;
    m_pass = (m_mis == 8'h00) && !m_failed;
`else
    m_pass = (m_mis == 8'h00);
`endif
  endtask

  task automatic model_reset();
    m_mis    = 8'h00;
    m_pass   = 1'b0;
    m_failed = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_abc"},   {29'd0, bus.a, bus.b, bus.c}, 32'd0);
    check_eq({tag, "_busy"},  bus.busy,        0);
    check_eq({tag, "_done"},  bus.done,        0);
    check_eq({tag, "_table"}, bus.truth_table, 0);
    check_eq({tag, "_mis"},   bus.mismatch,    0);
    check_eq({tag, "_pass"},  bus.pass,        0);
  endtask

  // One full sweep from IDLE with exact cycle timing (SETTLE=1).
  task automatic run_sweep(input int mode, input logic [7:0] pat);
    logic [7:0] tt;
    f_mode = mode;
    f_pat  = pat;
    tt     = model_table(mode, pat);
    bus.start = 1'b1;
    tick();                       // edge T: start accepted
    bus.start = 1'b0;
    check_eq("sw_busy_T",  bus.busy, 1);
    check_eq("sw_abc_T",   {29'd0, bus.a, bus.b, bus.c}, 0);
    check_eq("sw_tclr_T",  bus.truth_table, 0);
    for (int j = 1; j < 16; j++) begin
      tick();
      check_eq("sw_abc",  {29'd0, bus.a, bus.b, bus.c}, 32'(j / 2));
      check_eq("sw_busy", bus.busy, 1);
      check_eq("sw_done", bus.done, 0);
      check_eq("sw_mis_hold",  bus.mismatch, m_mis);
      check_eq("sw_pass_hold", bus.pass,     m_pass);
    end
    tick();                       // edge T+16
    model_complete(tt);
    check_eq("sw_done_T16", bus.done, 1);
    check_eq("sw_busy_T16", bus.busy, 0);
    check_eq("sw_abc_T16",  {29'd0, bus.a, bus.b, bus.c}, 0);
    check_eq("sw_table",    bus.truth_table, tt);
    check_eq("sw_mismatch", bus.mismatch,    m_mis);
    check_eq("sw_pass",     bus.pass,        m_pass);
    tick();                       // edge T+17: back to IDLE
    check_eq("sw_done_T17", bus.done, 0);
    check_eq("sw_table_hold", bus.truth_table, tt);
  endtask

  initial begin
    int first_done;
    int prev_done;
    int n_done;
    int bad_gap;
    int waited;
    int mode;
    logic [7:0] pat;

    rst_n     = 1'b0;
    bus.start = 1'b0;

    // Reset for two cycles, start low
    tick();
    tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || k == 19) begin
        check_eq("idle_busy", bus.busy, 0);
        check_eq("idle_done", bus.done, 0);
      end
    end

    // Real K-map: passes
    run_sweep(MODE_KMAP, 8'h00);
    // f tied low: fails
    run_sweep(MODE_ZERO, 8'h00);
    // Failing then passing sweep: sticky behaviour differs by build
    run_sweep(MODE_KMAP, 8'h00);

    // Start held high: done every 18 cycles, busy blocks restarts
    f_mode    = MODE_KMAP;
    bus.start = 1'b1;
    tick();                       // edge T
    first_done = -1;
    prev_done  = -1;
    n_done     = 0;
    bad_gap    = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = k;
        if (prev_done >= 0 && (k - prev_done) != 18) bad_gap++;
        prev_done = k;
        check_eq("b2b_busy_at_done", bus.busy, 0);
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_first_done", 32'(first_done), 16);
    check_eq("b2b_n_done",     32'(n_done),     3);
    check_eq("b2b_bad_gap",    32'(bad_gap),    0);
    model_complete(model_table(MODE_KMAP, 8'h00));
    waited = 0;
    while (bus.busy && waited < 40) begin
      tick();
      waited++;
    end
    check_eq("b2b_drain_timeout", 32'(bus.busy), 0);
    tick();
    tick();
    check_eq("b2b_mis",  bus.mismatch, m_mis);
    check_eq("b2b_pass", bus.pass,     m_pass);

    // Reset mid-sweep (held at the 5th edge after acceptance)
    f_mode    = MODE_KMAP;
    bus.start = 1'b1;
    tick();                       // edge T
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 1'b0;
    tick();                       // edge T+5 under reset
    rst_n = 1'b1;
    model_reset();
    check_all_zero("midrst");
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done || bus.busy) n_done++;
    end
    check_eq("midrst_no_activity", 32'(n_done), 0);
    run_sweep(MODE_KMAP, 8'h00);

    // Randomized sweeps with arbitrary f patterns and idle gaps
    for (int r = 0; r < 10; r++) begin
      mode = int'($urandom_range(0, 2));
      pat  = 8'($urandom);
      if (mode == MODE_PAT && $urandom_range(0, 3) == 0) pat = EXP_TT;
      run_sweep(mode, pat);
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        tick();
        check_eq("gap_busy", bus.busy, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
